// File: rtl/fp_div_prenorm.sv
// -----------------------------------------------------------------------------
// fp_div_prenorm
//
// Operand pre-normalisation stage in front of the combinational FP32 divider.
// Accepts a dividend/divisor pair, resolves every IEEE-754 special case
// locally, and left-shifts subnormal significands one bit per cycle until both
// have bit 23 set. The downstream core therefore only ever sees normal operands
// together with the sign and the biased quotient exponent.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds valid and data stable until that edge. out_valid and
// all out_* data stay stable until out_ready is seen high.
//
// Ports
//   clk             in   1   rising-edge clock
//   rst_n           in   1   asynchronous active-low reset
//   in_valid        in   1   operand pair valid
//   in_ready        out  1   block can accept (IDLE and rst_n high)
//   a, b            in   32  dividend / divisor, FP32 bits
//   out_valid       out  1   outputs valid, held until out_ready
//   out_ready       in   1   downstream accepts
//   out_sign        out  1   quotient sign (0 for NaN)
//   out_exp         out  10  signed, ea - eb + 127
//   out_man_a       out  24  normalised dividend significand
//   out_man_b       out  24  normalised divisor significand
//   out_special     out  1   out_special_res holds the final result
//   out_special_res out  32  final FP32 result for special cases, else 0
//   dbg_state       out  2   current FSM state (0 IDLE, 1 NORM, 2 OUT)
// -----------------------------------------------------------------------------
module fp_div_prenorm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sign,
   output logic [9:0]  out_exp,
   output logic [23:0] out_man_a,
   output logic [23:0] out_man_b,
   output logic        out_special,
   output logic [31:0] out_special_res,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_NORM = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [23:0]        man_a_q, man_a_d;
   logic [23:0]        man_b_q, man_b_d;
   logic signed [9:0]  ea_q, ea_d;
   logic signed [9:0]  eb_q, eb_d;
   logic               sign_q, sign_d;
   logic               special_q, special_d;
   logic [31:0]        special_res_q, special_res_d;

   // Raw operand classification
   logic [7:0]  a_exp, b_exp;
   logic [22:0] a_frac, b_frac;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic        sp_nan, sp_inf, sp_zero, is_special;
   logic        sign_ab;

   assign a_exp  = a[30:23];
   assign b_exp  = b[30:23];
   assign a_frac = a[22:0];
   assign b_frac = b[22:0];
   assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
   assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
   assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
   assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
   assign a_zero = (a_exp == 8'h00) && (a_frac == 23'd0);
   assign b_zero = (b_exp == 8'h00) && (b_frac == 23'd0);
   assign sign_ab = a[31] ^ b[31];

   // Priority is encoded by masking: once NaN cases are removed, any inf
   // dividend or zero divisor gives infinity; what remains with a zero
   // dividend or inf divisor gives zero.
   assign sp_nan     = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
   assign sp_inf     = !sp_nan & (a_inf | b_zero);
   assign sp_zero    = !sp_nan & !sp_inf & (a_zero | b_inf);
   assign is_special = sp_nan | sp_inf | sp_zero;

   always_comb begin
      state_d       = state_q;
      man_a_d       = man_a_q;
      man_b_d       = man_b_q;
      ea_d          = ea_q;
      eb_d          = eb_q;
      sign_d        = sign_q;
      special_d     = special_q;
      special_res_d = special_res_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               special_d = is_special;
               sign_d    = sp_nan ? 1'b0 : sign_ab;
               if (is_special) begin
                  man_a_d = 24'd0;
                  man_b_d = 24'd0;
                  ea_d    = 10'sd0;
                  eb_d    = 10'sd0;
                  if (sp_nan)
                     special_res_d = 32'h7FC0_0000;
                  else if (sp_inf)
                     special_res_d = {sign_ab, 8'hFF, 23'd0};
                  else
                     special_res_d = {sign_ab, 31'd0};
                  state_d = S_OUT;
               end else begin
                  // Subnormals carry the hidden-bit-less significand with the
                  // exponent of the smallest normal (1).
                  special_res_d = 32'd0;
                  man_a_d = {(a_exp != 8'd0), a_frac};
                  man_b_d = {(b_exp != 8'd0), b_frac};
                  ea_d    = (a_exp != 8'd0) ? $signed({2'b00, a_exp}) : 10'sd1;
                  eb_d    = (b_exp != 8'd0) ? $signed({2'b00, b_exp}) : 10'sd1;
                  state_d = S_NORM;
               end
            end
         end

         S_NORM: begin
            if (man_a_q[23] && man_b_q[23]) begin
               state_d = S_OUT;
            end else begin
               if (!man_a_q[23]) begin
                  man_a_d = {man_a_q[22:0], 1'b0};
                  ea_d    = ea_q - 10'sd1;
               end
               if (!man_b_q[23]) begin
                  man_b_d = {man_b_q[22:0], 1'b0};
                  eb_d    = eb_q - 10'sd1;
               end
            end
         end

         S_OUT: begin
            if (out_ready)
               state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         man_a_q       <= 24'd0;
         man_b_q       <= 24'd0;
         ea_q          <= 10'sd0;
         eb_q          <= 10'sd0;
         sign_q        <= 1'b0;
         special_q     <= 1'b0;
         special_res_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         man_a_q       <= man_a_d;
         man_b_q       <= man_b_d;
         ea_q          <= ea_d;
         eb_q          <= eb_d;
         sign_q        <= sign_d;
         special_q     <= special_d;
         special_res_q <= special_res_d;
      end
   end

   logic signed [9:0] exp_calc;
   assign exp_calc = ea_q - eb_q + 10'sd127;

   // Data outputs are forced to zero outside OUT so that reset and idle
   // present a clean all-zero bus.
   assign in_ready        = (state_q == S_IDLE) && rst_n;
   assign out_valid       = (state_q == S_OUT);
   assign out_sign        = out_valid & sign_q;
   assign out_exp         = (out_valid && !special_q) ? exp_calc : 10'd0;
   assign out_man_a       = out_valid ? man_a_q : 24'd0;
   assign out_man_b       = out_valid ? man_b_q : 24'd0;
   assign out_special     = out_valid & special_q;
   assign out_special_res = out_valid ? special_res_q : 32'd0;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_fp_div_prenorm.sv
// -----------------------------------------------------------------------------
// tb_fp_div_prenorm
//
// Directed bench for fp_div_prenorm. Expected results are built from hand
// computed constants, pushed to a queue when an operand pair is driven and
// popped when out_valid appears. Latency is measured in cycles counting the
// accept cycle as 1.
// -----------------------------------------------------------------------------
module tb_fp_div_prenorm;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [9:0]  out_exp;
   logic [23:0] out_man_a;
   logic [23:0] out_man_b;
   logic        out_special;
   logic [31:0] out_special_res;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [91:0] exp_q[$];
   int          lat_q[$];
   logic [91:0] last_obs;

   fp_div_prenorm dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .a               (a),
      .b               (b),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_sign        (out_sign),
      .out_exp         (out_exp),
      .out_man_a       (out_man_a),
      .out_man_b       (out_man_b),
      .out_special     (out_special),
      .out_special_res (out_special_res),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout obs=running exp=finished");
      $fatal(1, "global timeout");
   end

   // ---------------- helpers ----------------
   function automatic logic [91:0] mk(input logic s, input logic [9:0] e,
                                      input logic [23:0] ma, input logic [23:0] mb,
                                      input logic sp, input logic [31:0] res);
      return {s, e, ma, mb, sp, res};
   endfunction

   function automatic logic [91:0] observed();
      return {out_sign, out_exp, out_man_a, out_man_b, out_special, out_special_res};
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drives one pair (caller is #1 after an edge), waits for out_valid,
   // then checks latency and the scoreboard entry. Leaves time #1 after the
   // edge at which out_valid was first seen.
   task automatic send(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [91:0] expv, input int lat);
      int          cyc;
      logic [91:0] e;
      int          l;
      exp_q.push_back(expv);
      lat_q.push_back(lat);
      chk({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      chk({tag, "_latency"}, cyc, l);
      chk({tag, "_result"}, observed(), e);
      last_obs = observed();
   endtask

   // With out_ready high the handshake completes on the next edge.
   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_ready_back"}, in_ready, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = 32'd0;
      b         = 32'd0;
      out_ready = 1'b1;
      last_obs  = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outputs", observed(), 92'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Normal / normal: 1.0 / 2.0
      send("norm_1_2", 32'h3F80_0000, 32'h4000_0000,
           mk(1'b0, 10'd126, 24'h800000, 24'h800000, 1'b0, 32'd0), 2);
      drain("norm_1_2");

      // Specials, each one cycle
      send("inf_div_neg", 32'h7F80_0000, 32'h8563_4992,
           mk(1'b1, 10'd0, 24'd0, 24'd0, 1'b1, 32'hFF80_0000), 1);
      drain("inf_div_neg");
      send("zero_zero", 32'h0000_0000, 32'h0000_0000,
           mk(1'b0, 10'd0, 24'd0, 24'd0, 1'b1, 32'h7FC0_0000), 1);
      drain("zero_zero");
      send("nan_in", 32'h7FC0_0000, 32'h8563_4993,
           mk(1'b0, 10'd0, 24'd0, 24'd0, 1'b1, 32'h7FC0_0000), 1);
      drain("nan_in");
      send("zero_div_neg", 32'h0000_0000, 32'h8563_4992,
           mk(1'b1, 10'd0, 24'd0, 24'd0, 1'b1, 32'h8000_0000), 1);
      drain("zero_div_neg");
      send("inf_div_zero", 32'h7F80_0000, 32'h0000_0000,
           mk(1'b0, 10'd0, 24'd0, 24'd0, 1'b1, 32'h7F80_0000), 1);
      drain("inf_div_zero");
      send("fin_div_inf", 32'hC040_0000, 32'h7F80_0000,
           mk(1'b1, 10'd0, 24'd0, 24'd0, 1'b1, 32'h8000_0000), 1);
      drain("fin_div_inf");

      // Both subnormal: 9 and 6 shifts, ea=-8, eb=-5
      send("sub_sub", 32'h0000_5109, 32'h8003_4093,
           mk(1'b1, 10'd124, 24'hA21200, 24'hD024C0, 1'b0, 32'd0), 11);
      drain("sub_sub");

      // Worst case 23 shifts on the dividend: ea=-22, exp=-22
      send("min_sub_a", 32'h0000_0001, 32'h3F80_0000,
           mk(1'b0, 10'h3EA, 24'h800000, 24'h800000, 1'b0, 32'd0), 25);
      drain("min_sub_a");

      // Largest exponent: 254 - (-22) + 127 = 403
      send("max_exp", 32'h7F7F_FFFF, 32'h0000_0001,
           mk(1'b0, 10'd403, 24'hFFFFFF, 24'h800000, 1'b0, 32'd0), 25);
      drain("max_exp");

      // Back-pressure: -1.0 / 1.0 held for 5 cycles
      out_ready = 1'b0;
      send("bp", 32'hBF80_0000, 32'h3F80_0000,
           mk(1'b1, 10'd127, 24'h800000, 24'h800000, 1'b0, 32'd0), 2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_data", observed(), last_obs);
         chk("bp_hold_in_ready", in_ready, 0);
      end
      drain("bp");
      // Accepted on the very next cycle: 3.0 / -2.0
      send("bp_next", 32'h4040_0000, 32'hC000_0000,
           mk(1'b1, 10'd127, 24'hC00000, 24'h800000, 1'b0, 32'd0), 2);
      drain("bp_next");

      // Reset during NORM
      in_valid = 1'b1;
      a        = 32'h0000_0001;
      b        = 32'h0000_0001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_norm_valid", out_valid, 0);
      chk("rst_norm_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset during OUT: out_valid must fall without a clock edge
      out_ready = 1'b0;
      send("pre_rst_out", 32'h4000_0000, 32'h3F80_0000,
           mk(1'b0, 10'd128, 24'h800000, 24'h800000, 1'b0, 32'd0), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", observed(), 92'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Clean restart with 2-cycle latency: 1.5 / 0.5
      send("after_rst", 32'h3FC0_0000, 32'h3F00_0000,
           mk(1'b0, 10'd128, 24'hC00000, 24'h800000, 1'b0, 32'd0), 2);
      drain("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
